pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller that drives the PC register and the IF/ID stage hold inputs.

---
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: PC/IF/ID sequencing -- redirect and stall merge,
// squash window, JTAG halt handshake and bus-stall watchdog.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned BUS_TIMEOUT  = 1024,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              int_assert_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  input  logic              ex_hold_i,
  input  logic              clint_hold_i,
  input  logic              bus_hold_i,
  input  logic              jtag_halt_req_i,
  input  logic              jtag_reset_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [2:0]        hold_flag_o,
  output logic              jtag_reset_flag_o,
  output logic              jtag_halt_ack_o,
  output logic              flush_busy_o,
  output logic              bus_timeout_o
);

  localparam logic [2:0] HoldNone = 3'd0;
  localparam logic [2:0] HoldPc   = 3'd1;
  localparam logic [2:0] HoldId   = 3'd3;

  localparam logic [3:0]  FlushLoad = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] BusMax    = 16'(BUS_TIMEOUT);
  localparam logic [15:0] BusLast   = 16'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    Run,
    HaltPend,
    Halted
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] bus_cnt_q, bus_cnt_d;
  logic        jrst_q;
  logic        ack_q, ack_d;
  logic        tmo_q, tmo_d;

  logic jump_flag;
  logic flush_busy;
  logic drained;

  always_comb begin
    jump_flag   = 1'b0;
    jump_addr_o = '0;
    flush_busy  = 1'b0;
    drained     = 1'b0;
    hold_flag_o = HoldNone;

    jump_flag = rst_ni & (int_assert_i | jump_req_i)
              & (state_q != Halted);
    if (jump_flag) begin
      jump_addr_o = int_assert_i ? int_addr_i : jump_addr_i;
    end

    flush_busy = rst_ni & (jump_flag | (flush_cnt_q != 4'd0));
    drained    = ~ex_hold_i & ~clint_hold_i & ~flush_busy;

    if (rst_ni) begin
      if (flush_busy | ex_hold_i | clint_hold_i
          | (state_q == Halted)
          | ((state_q == HaltPend) & drained)) begin
        hold_flag_o = HoldId;
      end else if (bus_hold_i) begin
        hold_flag_o = HoldPc;
      end
    end
  end

  assign jump_flag_o  = jump_flag;
  assign flush_busy_o = flush_busy;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;

    if (jrst_q) begin
      flush_cnt_d = 4'd0;
    end else if (jump_flag) begin
      flush_cnt_d = FlushLoad;
    end else if (flush_cnt_q != 4'd0) begin
      flush_cnt_d = flush_cnt_q - 4'd1;
    end

    unique case (state_q)
      Run: begin
        if (jtag_halt_req_i) state_d = HaltPend;
      end
      HaltPend: begin
        if (!jtag_halt_req_i) state_d = Run;
        else if (drained)     state_d = Halted;
      end
      Halted: begin
        if (!jtag_halt_req_i) state_d = Run;
      end
      default: state_d = Run;
    endcase
    // debug reset overrides the handshake
    if (jrst_q) state_d = Run;

    ack_d = (state_d == Halted);
  end

  always_comb begin
    bus_cnt_d = 16'd0;
    if (bus_hold_i) begin
      bus_cnt_d = (bus_cnt_q == BusMax) ? bus_cnt_q
                                        : bus_cnt_q + 16'd1;
    end
    tmo_d = tmo_q | (bus_hold_i & (bus_cnt_q == BusLast));
    if (jrst_q) tmo_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= Run;
      flush_cnt_q <= 4'd0;
      bus_cnt_q   <= 16'd0;
      jrst_q      <= 1'b0;
      ack_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      bus_cnt_q   <= bus_cnt_d;
      jrst_q      <= jtag_reset_i;
      ack_q       <= ack_d;
      tmo_q       <= tmo_d;
    end
  end

  assign jtag_reset_flag_o = jrst_q;
  assign jtag_halt_ack_o   = ack_q;
  assign bus_timeout_o     = tmo_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + random stimulus against a
// cycle-level reference model of the sequencing rules.
module tb_pipe_ctrl;
  localparam int F  = 2;
  localparam int BT = 4;

  logic        clk = 1'b0;
  logic        rst_n, jreq, intr, exh, clh, bush, hreq, jrst;
  logic [31:0] ja, ia, jaddr_o;
  logic        jf_o, jrf_o, ack_o, busy_o, tmo_o;
  logic [2:0]  hold_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(F), .BUS_TIMEOUT(BT), .ADDR_W(32)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .jump_req_i(jreq),
    .jump_addr_i(ja),
    .int_assert_i(intr),
    .int_addr_i(ia),
    .ex_hold_i(exh),
    .clint_hold_i(clh),
    .bus_hold_i(bush),
    .jtag_halt_req_i(hreq),
    .jtag_reset_i(jrst),
    .jump_flag_o(jf_o),
    .jump_addr_o(jaddr_o),
    .hold_flag_o(hold_o),
    .jtag_reset_flag_o(jrf_o),
    .jtag_halt_ack_o(ack_o),
    .flush_busy_o(busy_o),
    .bus_timeout_o(tmo_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cyc        = 0;
  int last_redir = -100;
  int stall_run  = 0;
  bit m_halted   = 0;
  bit m_pend     = 0;
  bit m_jrst     = 0;
  bit m_tmo      = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic set(bit r, bit jq, logic [31:0] a, bit it,
                     logic [31:0] b, bit e, bit c, bit bs,
                     bit h, bit jr);
    rst_n = r; jreq = jq; ja = a; intr = it; ia = b;
    exh = e; clh = c; bush = bs; hreq = h; jrst = jr;
  endtask

  task automatic step();
    logic        ejf, ebusy;
    logic [31:0] eaddr;
    logic [2:0]  ehold;
    bit          drained;
    #1;
    ejf   = rst_n & (jreq | intr) & !m_halted;
    eaddr = !ejf ? 32'h0 : (intr ? ia : ja);
    ebusy = rst_n & (ejf | ((cyc - last_redir) < F));
    if (!rst_n) ehold = 3'd0;
    else if (ebusy | exh | clh | m_halted | m_pend) ehold = 3'd3;
    else if (bush) ehold = 3'd1;
    else ehold = 3'd0;

    check("jump_flag", 32'(jf_o), 32'(ejf));
    check("jump_addr", jaddr_o, eaddr);
    check("flush_busy", 32'(busy_o), 32'(ebusy));
    check("hold_flag", 32'(hold_o), 32'(ehold));
    check("jtag_reset_flag", 32'(jrf_o), 32'(m_jrst));
    check("halt_ack", 32'(ack_o), 32'(m_halted));
    check("bus_timeout", 32'(tmo_o), 32'(m_tmo));

    @(posedge clk);
    if (!rst_n) begin
      last_redir = -100; stall_run = 0;
      m_halted = 0; m_pend = 0; m_jrst = 0; m_tmo = 0;
    end else begin
      drained = !exh & !clh & !ebusy;
      if (m_jrst) last_redir = -100;
      else if (ejf) last_redir = cyc;

      if (m_jrst) begin
        m_halted = 0; m_pend = 0;
      end else if (m_halted) begin
        if (!hreq) m_halted = 0;
      end else if (m_pend) begin
        if (!hreq) m_pend = 0;
        else if (drained) begin m_pend = 0; m_halted = 1; end
      end else if (hreq) begin
        m_pend = 1;
      end

      stall_run = bush ? stall_run + 1 : 0;
      if (m_jrst) m_tmo = 0;
      else if (stall_run == BT) m_tmo = 1;
      m_jrst = jrst;
    end
    cyc++;
    #1;
  endtask

  initial begin
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    repeat (2) step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // redirect and squash window
    set(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0); step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();

    // interrupt beats jump
    set(1, 1, 32'h100, 1, 32'h80, 0, 0, 0, 0, 0); step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();

    // halt behind a multi-cycle op
    set(1, 0, 0, 0, 0, 1, 0, 0, 0, 0); step();
    set(1, 0, 0, 0, 0, 1, 0, 0, 1, 0); repeat (4) step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); repeat (3) step();

    // redirect ignored while halted, then release
    set(1, 1, 32'h200, 0, 0, 0, 0, 0, 1, 0); step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();

    // bus stall watchdog
    set(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); repeat (6) step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // debug reset while halted clears timeout and halt
    set(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); repeat (3) step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();

    // core reset in the middle of a squash window
    set(1, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0); step();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(9) == 0) hreq = ~hreq;
      if ($urandom_range(6) == 0) bush = ~bush;
      rst_n = ($urandom_range(99) != 0);
      jreq  = ($urandom_range(4) == 0);
      intr  = ($urandom_range(9) == 0);
      ja    = $urandom;
      ia    = $urandom;
      exh   = ($urandom_range(4) == 0);
      clh   = ($urandom_range(9) == 0);
      jrst  = ($urandom_range(29) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
